// File: rtl/mips_alu_pkg.sv
// Shared ALU op codes, MIPS opcode/funct constants and the issue-entry bundle
// used by the ID->EX issue stage (alu_op_decode, alu_op_issue).
package mips_alu_pkg;

    localparam int XLEN = 64;

    localparam logic [3:0] ALU_NOP  = 4'h0;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_ADD  = 4'h4;
    localparam logic [3:0] ALU_AND  = 4'h5;
    localparam logic [3:0] ALU_SUB  = 4'h7;
    localparam logic [3:0] ALU_SLL  = 4'h8;
    localparam logic [3:0] ALU_SRL  = 4'h9;
    localparam logic [3:0] ALU_LUI  = 4'hB;
    localparam logic [3:0] ALU_SLT  = 4'hC;
    localparam logic [3:0] ALU_SLTU = 4'hD;
    localparam logic [3:0] ALU_NOR  = 4'hE;
    localparam logic [3:0] ALU_PASS = 4'hF;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_SLTIU = 6'h0B;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef struct packed {
        logic [3:0]      operation;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [4:0]      shamt;
        logic            illegal;
    } issue_entry_t;

    function automatic logic [XLEN-1:0] sext16(input logic [15:0] imm);
        return {{(XLEN-16){imm[15]}}, imm};
    endfunction

    function automatic logic [XLEN-1:0] zext16(input logic [15:0] imm);
        return {{(XLEN-16){1'b0}}, imm};
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational MIPS instruction + operand decode into one ALU issue entry.
// Unknown opcode/funct yields a zeroed no-op entry flagged illegal.
module alu_op_decode
    import mips_alu_pkg::*;
(
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    output issue_entry_t    entry
);

    logic [5:0]  w_opc;
    logic [5:0]  w_fn;
    logic [15:0] w_imm;

    assign w_opc = instr[31:26];
    assign w_fn  = instr[5:0];
    assign w_imm = instr[15:0];

    always_comb begin
        entry = '0;
        case (w_opc)
            OPC_RTYPE: begin
                entry.op1 = rs_data;
                entry.op2 = rt_data;
                case (w_fn)
                    FN_ADD, FN_ADDU: entry.operation = ALU_ADD;
                    FN_SUB, FN_SUBU: begin
                        // ALU computes op2 - op1, so operands swap
                        entry.operation = ALU_SUB;
                        entry.op1       = rt_data;
                        entry.op2       = rs_data;
                    end
                    FN_AND:  entry.operation = ALU_AND;
                    FN_OR:   entry.operation = ALU_OR;
                    FN_NOR:  entry.operation = ALU_NOR;
                    FN_SLT:  entry.operation = ALU_SLT;
                    FN_SLTU: entry.operation = ALU_SLTU;
                    FN_SLL: begin
                        entry.operation = ALU_SLL;
                        entry.shamt     = instr[10:6];
                    end
                    FN_SRL: begin
                        entry.operation = ALU_SRL;
                        entry.shamt     = instr[10:6];
                    end
                    FN_JR: begin
                        entry.operation = ALU_PASS;
                        entry.op2       = rs_data;
                    end
                    default: begin
                        entry         = '0;
                        entry.illegal = 1'b1;
                    end
                endcase
            end
            OPC_ADDI, OPC_ADDIU, OPC_LW, OPC_SW: begin
                entry.operation = ALU_ADD;
                entry.op1       = rs_data;
                entry.op2       = sext16(w_imm);
            end
            OPC_SLTI: begin
                entry.operation = ALU_SLT;
                entry.op1       = rs_data;
                entry.op2       = sext16(w_imm);
            end
            OPC_SLTIU: begin
                entry.operation = ALU_SLTU;
                entry.op1       = rs_data;
                entry.op2       = sext16(w_imm);
            end
            OPC_ANDI: begin
                entry.operation = ALU_AND;
                entry.op1       = rs_data;
                entry.op2       = zext16(w_imm);
            end
            OPC_ORI: begin
                entry.operation = ALU_OR;
                entry.op1       = rs_data;
                entry.op2       = zext16(w_imm);
            end
            OPC_LUI: begin
                entry.operation = ALU_LUI;
                entry.op1       = rs_data;
                entry.op2       = zext16(w_imm);
            end
            OPC_BEQ, OPC_BNE: begin
                entry.operation = ALU_SUB;
                entry.op1       = rt_data;
                entry.op2       = rs_data;
            end
            default: entry.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_op_issue.sv
// ID->EX issue stage: decode, 2-entry skid buffer, valid/ready handshakes.
// Optional `ILLEGAL_TRAP_EN: retiring an illegal entry stalls input until flush.
module alu_op_issue
    import mips_alu_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        operation,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2,
    output logic [4:0]        shamt,
    output logic              illegal
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    issue_entry_t r_buf [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_count;

    issue_entry_t w_dec;
    issue_entry_t w_head;
    logic         w_push;
    logic         w_pop;
    logic         w_room;

    alu_op_decode u_dec (
        .instr   (instr),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .entry   (w_dec)
    );

    assign w_room    = (r_count < FULL);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign w_head    = out_valid ? r_buf[r_rptr] : '0;

    assign operation = w_head.operation;
    assign op1       = w_head.op1;
    assign op2       = w_head.op2;
    assign shamt     = w_head.shamt;
    assign illegal   = w_head.illegal;

`ifdef ILLEGAL_TRAP_EN
    logic r_trap;

    always_ff @(posedge clk) begin
        if (!rst_n || flush)
            r_trap <= 1'b0;
        else if (w_pop && w_head.illegal)
            r_trap <= 1'b1;
    end

    assign in_ready = w_room & ~r_trap;
`else
    assign in_ready = w_room;
`endif

    // Flush shares the reset path so a same-cycle accept is dropped
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push)
                r_wptr <= ~r_wptr;
            if (w_pop)
                r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++)
                r_buf[i] <= '0;
        end else if (w_push && !flush) begin
            r_buf[r_wptr] <= w_dec;
        end
    end

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed self-checking bench for alu_op_issue: decode table, back-pressure,
// flush, mid-stream reset and illegal handling (trap mode when ILLEGAL_TRAP_EN).
module tb_alu_op_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [63:0] rs_data;
    logic [63:0] rt_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  operation;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [4:0]  shamt;
    logic        illegal;

    int checks = 0;
    int errors = 0;

`ifdef ILLEGAL_TRAP_EN
    localparam logic TRAP_ON = 1'b1;
`else
    localparam logic TRAP_ON = 1'b0;
`endif

    typedef struct {
        logic [31:0] i;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  op;
        logic [63:0] o1;
        logic [63:0] o2;
        logic [4:0]  sh;
    } vec_t;

    always #5 clk = ~clk;

    alu_op_issue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .operation (operation),
        .op1       (op1),
        .op2       (op2),
        .shamt     (shamt),
        .illegal   (illegal)
    );

    // Present one instruction across one rising edge, then drop in_valid
    task automatic drive(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        instr    = i;
        rs_data  = a;
        rt_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        instr     = '0;
        rs_data   = '0;
        rt_data   = '0;
        idle(2);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reset_hs got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        checks++;
        if ({operation, op1, op2, shamt, illegal} !== '0) begin
            errors++;
            $display("FAIL reset_data got op=%h op1=%h op2=%h sh=%h il=%b want all 0",
                     operation, op1, op2, shamt, illegal);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_decode;
        vec_t v [22];
        v[0]  = '{32'h00221820, 64'd5, 64'd7, 4'h4, 64'd5, 64'd7, 5'd0};
        v[1]  = '{32'h00221860, 64'd5, 64'd7, 4'h4, 64'd5, 64'd7, 5'd0};
        v[2]  = '{32'h00221822, 64'd10, 64'd3, 4'h7, 64'd3, 64'd10, 5'd0};
        v[3]  = '{32'h00221823, 64'd10, 64'd3, 4'h7, 64'd3, 64'd10, 5'd0};
        v[4]  = '{32'h00221824, 64'hF0, 64'h3C, 4'h5, 64'hF0, 64'h3C, 5'd0};
        v[5]  = '{32'h00221825, 64'hF0, 64'h3C, 4'h3, 64'hF0, 64'h3C, 5'd0};
        v[6]  = '{32'h00221827, 64'hF0, 64'h3C, 4'hE, 64'hF0, 64'h3C, 5'd0};
        v[7]  = '{32'h0022182A, 64'd1, 64'd2, 4'hC, 64'd1, 64'd2, 5'd0};
        v[8]  = '{32'h0022182B, 64'd1, 64'd2, 4'hD, 64'd1, 64'd2, 5'd0};
        v[9]  = '{32'h00021940, 64'd0, 64'h81, 4'h8, 64'd0, 64'h81, 5'd5};
        v[10] = '{32'h000218C2, 64'd0, 64'h80, 4'h9, 64'd0, 64'h80, 5'd3};
        v[11] = '{32'h00200008, 64'h77, 64'h33, 4'hF, 64'h77, 64'h77, 5'd0};
        v[12] = '{32'h2022FFFF, 64'd1, 64'd2, 4'h4, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0};
        v[13] = '{32'h24220010, 64'd1, 64'd2, 4'h4, 64'd1, 64'h10, 5'd0};
        v[14] = '{32'h28228000, 64'd3, 64'd0, 4'hC, 64'd3, 64'hFFFF_FFFF_FFFF_8000, 5'd0};
        v[15] = '{32'h2C220005, 64'd3, 64'd0, 4'hD, 64'd3, 64'd5, 5'd0};
        v[16] = '{32'hAC22FFF0, 64'h100, 64'd0, 4'h4, 64'h100, 64'hFFFF_FFFF_FFFF_FFF0, 5'd0};
        v[17] = '{32'h30228000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'h5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000, 5'd0};
        v[18] = '{32'h3422FFFF, 64'd0, 64'd0, 4'h3, 64'd0, 64'h0000_0000_0000_FFFF, 5'd0};
        v[19] = '{32'h3C021234, 64'd0, 64'd0, 4'hB, 64'd0, 64'h1234, 5'd0};
        v[20] = '{32'h10220000, 64'd9, 64'd9, 4'h7, 64'd9, 64'd9, 5'd0};
        v[21] = '{32'h14220004, 64'd20, 64'd6, 4'h7, 64'd6, 64'd20, 5'd0};
        out_ready = 1'b1;
        for (int n = 0; n < 22; n++) begin
            drive(v[n].i, v[n].a, v[n].b);
            checks++;
            if ({out_valid, operation, op1, op2, shamt, illegal} !==
                {1'b1, v[n].op, v[n].o1, v[n].o2, v[n].sh, 1'b0}) begin
                errors++;
                $display("FAIL decode[%0d] instr=%h got v=%b op=%h op1=%h op2=%h sh=%0d il=%b want op=%h op1=%h op2=%h sh=%0d",
                         n, v[n].i, out_valid, operation, op1, op2, shamt, illegal,
                         v[n].op, v[n].o1, v[n].o2, v[n].sh);
            end
        end
        idle(1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL decode_drain got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        drive(32'h00221820, 64'd1, 64'd0);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_one_ready got %b want 1", in_ready);
        end
        drive(32'h00221820, 64'd2, 64'd0);
        checks++;
        if ({in_ready, out_valid, op1} !== {1'b0, 1'b1, 64'd1}) begin
            errors++;
            $display("FAIL bp_full got in_ready=%b out_valid=%b op1=%h want 0 1 1", in_ready, out_valid, op1);
        end
        drive(32'h00221820, 64'd3, 64'd0);
        checks++;
        if ({in_ready, op1} !== {1'b0, 64'd1}) begin
            errors++;
            $display("FAIL bp_blocked got in_ready=%b op1=%h want 0 1", in_ready, op1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        idle(1);
        checks++;
        if ({in_ready, out_valid, op1} !== {1'b1, 1'b1, 64'd2}) begin
            errors++;
            $display("FAIL bp_second got in_ready=%b out_valid=%b op1=%h want 1 1 2", in_ready, out_valid, op1);
        end
        idle(1);
        checks++;
        if ({out_valid, op1} !== {1'b0, 64'd0}) begin
            errors++;
            $display("FAIL bp_empty got out_valid=%b op1=%h want 0 0", out_valid, op1);
        end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        drive(32'h00221820, 64'hA1, 64'd0);
        drive(32'h00221820, 64'hA2, 64'd0);
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        instr    = 32'h00221820;
        rs_data  = 64'hA3;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, in_ready, op1, operation} !== {1'b0, 1'b1, 64'd0, 4'h0}) begin
            errors++;
            $display("FAIL flush got out_valid=%b in_ready=%b op1=%h op=%h want 0 1 0 0",
                     out_valid, in_ready, op1, operation);
        end
        out_ready = 1'b1;
        drive(32'h00221820, 64'h55, 64'd0);
        checks++;
        if ({out_valid, op1} !== {1'b1, 64'h55}) begin
            errors++;
            $display("FAIL flush_refill got out_valid=%b op1=%h want 1 55", out_valid, op1);
        end
        idle(1);
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        drive(32'h00221820, 64'hB1, 64'd0);
        drive(32'h00221820, 64'hB2, 64'd0);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        rs_data  = 64'hB3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, in_ready, operation, op1, op2, shamt, illegal} !==
            {1'b0, 1'b1, 4'h0, 64'd0, 64'd0, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid got out_valid=%b in_ready=%b op=%h op1=%h op2=%h",
                     out_valid, in_ready, operation, op1, op2);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle(1);
    endtask

    task automatic test_illegal;
        logic [31:0] bad [2];
        bad[0] = 32'h0000003F;
        bad[1] = 32'hFC000000;
        out_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            drive(bad[n], 64'd5, 64'd7);
            checks++;
            if ({out_valid, operation, op1, op2, shamt, illegal} !==
                {1'b1, 4'h0, 64'd0, 64'd0, 5'd0, 1'b1}) begin
                errors++;
                $display("FAIL illegal[%0d] got v=%b op=%h op1=%h op2=%h il=%b want 1 0 0 0 1",
                         n, out_valid, operation, op1, op2, illegal);
            end
            idle(2);
            checks++;
            if ({out_valid, illegal, in_ready} !== {1'b0, 1'b0, ~TRAP_ON}) begin
                errors++;
                $display("FAIL illegal_retire[%0d] got out_valid=%b illegal=%b in_ready=%b want 0 0 %b",
                         n, out_valid, illegal, in_ready, ~TRAP_ON);
            end
            @(negedge clk);
            flush = 1'b1;
            @(posedge clk);
            #1;
            flush = 1'b0;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL illegal_flush[%0d] got in_ready=%b want 1", n, in_ready);
            end
        end
    endtask

    initial begin
        test_reset;
        test_decode;
        test_backpressure;
        test_flush;
        test_reset_mid;
        test_illegal;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
